// File: rtl/demux_sched_pkg.sv
// Shared types and helpers for the demux credit scheduler: channel count,
// select width, FSM state encoding and the rotating channel picker.
package demux_sched_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        BLOCKED = 2'd2
    } sched_state_t;

    // First channel at or after ptr (wrapping) whose bit is set in nz_mask;
    // returns ptr when no channel qualifies.
    function automatic logic [SEL_W-1:0] next_rr(input logic [SEL_W-1:0]  ptr,
                                                 input logic [NUM_CH-1:0] nz_mask);
        logic [SEL_W-1:0] ch_s;
        logic             found_s;
        next_rr = ptr;
        found_s = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            ch_s = ptr + k[SEL_W-1:0];
            if (!found_s && nz_mask[ch_s]) begin
                next_rr = ch_s;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    endfunction

endpackage

// File: rtl/demux_credit_ctr.sv
// One per-channel credit counter: loads CREDITS at reset, decrements on
// dispatch, increments on return and saturates with an overflow flag.
module demux_credit_ctr #(
    parameter int CREDITS = 4,
    parameter int CRED_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec,
    input  logic              inc,
    output logic [CRED_W-1:0] cnt,
    output logic [CRED_W-1:0] cnt_nxt,
    output logic              ovf
);

    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);

    logic [CRED_W-1:0] cnt_r;
    logic [CRED_W-1:0] cnt_nxt_s;
    logic              ovf_s;

    // Next credit value; a simultaneous dispatch and return cancel out.
    always_comb begin
        cnt_nxt_s = cnt_r;
        ovf_s     = 1'b0;
        case ({dec, inc})
            2'b10: begin
                if (cnt_r != {CRED_W{1'b0}}) begin
                    cnt_nxt_s = cnt_r - CRED_W'(1'b1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            2'b01: begin
                if (cnt_r == CRED_MAX) begin
                    cnt_nxt_s = cnt_r;
                    ovf_s     = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + CRED_W'(1'b1);
                end
            end
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // Credit register, full credit after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= CRED_MAX;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign cnt     = cnt_r;
    assign cnt_nxt = cnt_nxt_s;
    assign ovf     = ovf_s;

endmodule

// File: rtl/demux_credit_scheduler.sv
// Credit-based feeder for the 1x4 demux: picks a channel with credit, registers
// A/S one cycle after acceptance. DEMUX_SCHED_STRICT_PRIO_EN selects fixed priority.
module demux_credit_scheduler
    import demux_sched_pkg::*;
#(
    parameter int DATA_W  = 1,
    parameter int CREDITS = 4,
    parameter int CRED_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [3:0]        credit_ret,
    output logic [DATA_W-1:0] A,
    output logic [1:0]        S,
    output logic              out_valid,
    output logic              blocked,
    output logic              err_credit
);

    logic [CRED_W-1:0] cnt_s     [NUM_CH];
    logic [CRED_W-1:0] cnt_nxt_s [NUM_CH];
    logic [NUM_CH-1:0] ovf_s;
    logic [NUM_CH-1:0] nz_mask_s;
    logic [NUM_CH-1:0] nxt_nz_mask_s;
    logic [NUM_CH-1:0] dec_s;
    logic [SEL_W-1:0]  grant_s;
    logic              transfer_s;
    sched_state_t      state_r;
    sched_state_t      state_nxt_s;
    logic [SEL_W-1:0]  ptr_r;
    logic [DATA_W-1:0] a_r;
    logic [SEL_W-1:0]  s_r;
    logic              out_valid_r;
    logic              in_ready_r;
    logic              blocked_r;
    logic              err_r;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ctr
        demux_credit_ctr #(
            .CREDITS (CREDITS),
            .CRED_W  (CRED_W)
        ) u_ctr (
            .clk     (clk),
            .rst     (rst),
            .dec     (dec_s[g]),
            .inc     (credit_ret[g]),
            .cnt     (cnt_s[g]),
            .cnt_nxt (cnt_nxt_s[g]),
            .ovf     (ovf_s[g])
        );
        assign nz_mask_s[g]     = (cnt_s[g] != {CRED_W{1'b0}});
        assign nxt_nz_mask_s[g] = (cnt_nxt_s[g] != {CRED_W{1'b0}});
    end

    // Arbiter: in strict-priority builds ptr stays 0, so the search starts at ch0.
    always_comb begin
        grant_s    = next_rr(ptr_r, nz_mask_s);
        transfer_s = in_valid && in_ready_r;
        dec_s      = {NUM_CH{1'b0}};
        if (transfer_s) begin
            dec_s[grant_s] = 1'b1;
        end else begin
            dec_s = {NUM_CH{1'b0}};
        end
    end

    // Next state looks at post-update credits so a return unblocks in one cycle.
    always_comb begin
        state_nxt_s = state_r;
        if (!enable) begin
            state_nxt_s = IDLE;
        end else if (nxt_nz_mask_s == {NUM_CH{1'b0}}) begin
            state_nxt_s = BLOCKED;
        end else begin
            state_nxt_s = RUN;
        end
    end

    // FSM, pointer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            ptr_r       <= {SEL_W{1'b0}};
            a_r         <= {DATA_W{1'b0}};
            s_r         <= {SEL_W{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b0;
            blocked_r   <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            in_ready_r <= (state_nxt_s == RUN);
            blocked_r  <= (state_nxt_s == BLOCKED);
            err_r      <= err_r | (|ovf_s);
            if (transfer_s) begin
                a_r         <= in_data;
                s_r         <= grant_s;
                out_valid_r <= 1'b1;
`ifdef DEMUX_SCHED_STRICT_PRIO_EN
                ptr_r       <= {SEL_W{1'b0}};
`else
                ptr_r       <= grant_s + SEL_W'(1'b1);
`endif
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign A          = a_r;
    assign S          = s_r;
    assign out_valid  = out_valid_r;
    assign blocked    = blocked_r;
    assign err_credit = err_r;

endmodule

// File: tb/tb_demux_credit_scheduler.sv
// Directed self-checking bench for demux_credit_scheduler (default parameters).
module tb_demux_credit_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       in_valid;
    logic [0:0] in_data;
    logic       in_ready;
    logic [3:0] credit_ret;
    logic [0:0] A;
    logic [1:0] S;
    logic       out_valid;
    logic       blocked;
    logic       err_credit;

    int n_checks = 0;
    int n_errors = 0;

    demux_credit_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .credit_ret (credit_ret),
        .A          (A),
        .S          (S),
        .out_valid  (out_valid),
        .blocked    (blocked),
        .err_credit (err_credit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        enable     = 1'b0;
        in_valid   = 1'b0;
        in_data    = 1'b0;
        credit_ret = 4'b0000;
        #3;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        logic [1:0] exp_s;
        logic [1:0] seq_c [7];
        seq_c = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1};

        do_reset();
        chk("rst_A", A, 0);
        chk("rst_S", S, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_err", err_credit, 0);
        chk("rst_in_ready", in_ready, 0);

        enable = 1'b1;
        tick();
        chk("run_in_ready", in_ready, 1);

        // 16 items drain all credits
        for (int i = 0; i < 16; i++) begin
`ifdef DEMUX_SCHED_STRICT_PRIO_EN
            exp_s = 2'(i / 4);
`else
            exp_s = 2'(i % 4);
`endif
            in_valid = 1'b1;
            in_data  = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            chk("seq_S", S, exp_s);
            chk("seq_A", A, (i % 2 == 0) ? 1 : 0);
            chk("seq_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        chk("drained_blocked", blocked, 1);
        chk("drained_in_ready", in_ready, 0);
        tick();
        chk("idle_out_valid", out_valid, 0);
        chk("hold_A", A, 0);

`ifndef DEMUX_SCHED_STRICT_PRIO_EN
        // ch0 stays empty: credits become 0,2,2,2 with ptr=0
        credit_ret = 4'b1110;
        tick();
        tick();
        credit_ret = 4'b0000;
        chk("skip0_in_ready", in_ready, 1);
        chk("skip0_blocked", blocked, 0);
        for (int i = 0; i < 7; i++) begin
            in_valid   = 1'b1;
            in_data    = 1'b1;
            credit_ret = (i == 3) ? 4'b0010 : 4'b0000;
            tick();
            chk("skip0_S", S, seq_c[i]);
            chk("skip0_out_valid", out_valid, 1);
        end
        in_valid   = 1'b0;
        credit_ret = 4'b0000;
        chk("skip0_blocked_end", blocked, 1);
        chk("skip0_err", err_credit, 0);

        // single return to ch2 unblocks for exactly one item
        chk("unblk_pre_ready", in_ready, 0);
        credit_ret = 4'b0100;
        tick();
        credit_ret = 4'b0000;
        chk("unblk_in_ready", in_ready, 1);
        chk("unblk_blocked", blocked, 0);
        in_valid = 1'b1;
        in_data  = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("unblk_S", S, 2);
        chk("unblk_out_valid", out_valid, 1);
        chk("reblk_blocked", blocked, 1);
        chk("reblk_in_ready", in_ready, 0);
`endif

        // return at full credit flags a sticky error and does not add credit
        do_reset();
        enable = 1'b1;
        tick();
        credit_ret = 4'b0001;
        tick();
        credit_ret = 4'b0000;
        chk("err_set", err_credit, 1);
        tick();
        chk("err_sticky", err_credit, 1);
        in_valid = 1'b1;
        in_data  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
        end
        in_valid = 1'b0;
        chk("err_blocked16", blocked, 1);
        chk("err_in_ready16", in_ready, 0);
        chk("err_still", err_credit, 1);

        // enable dropped: the same-edge item completes, nothing more accepted
        do_reset();
        enable = 1'b1;
        tick();
        in_valid = 1'b1;
        in_data  = 1'b1;
        enable   = 1'b0;
        tick();
        chk("en_off_out_valid", out_valid, 1);
        chk("en_off_in_ready", in_ready, 0);
        tick();
        chk("en_off_no_more", out_valid, 0);
        enable = 1'b1;
        tick();
        tick();
        chk("en_resume_S", S, 1);

        // asynchronous reset mid-stream
        do_reset();
        enable   = 1'b1;
        tick();
        in_valid = 1'b1;
        in_data  = 1'b1;
        tick();
        tick();
        chk("pre_arst_out_valid", out_valid, 1);
        chk("pre_arst_A", A, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_A", A, 0);
        chk("arst_S", S, 0);
        rst = 1'b0;
        #1;
        tick();
        chk("post_arst_out_valid", out_valid, 0);
        tick();
        chk("post_arst_S", S, 0);
        chk("post_arst_valid", out_valid, 1);
        in_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
